// File: rtl/div_unit_pkg.sv
// Shared CPU definitions: pipeline op classes, divider op encodings and
// divider FSM state encodings.
package div_unit_pkg;

    localparam logic [2:0] EX_OP_ALU    = 3'd0;
    localparam logic [2:0] EX_OP_MUL    = 3'd1;
    localparam logic [2:0] EX_OP_DIV    = 3'd2;
    localparam logic [2:0] EX_OP_LSU    = 3'd3;
    localparam logic [2:0] EX_OP_BRANCH = 3'd4;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic [1:0] DIV_ST_IDLE = 2'd0;
    localparam logic [1:0] DIV_ST_CALC = 2'd1;
    localparam logic [1:0] DIV_ST_DONE = 2'd2;

    function automatic logic div_op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    function automatic logic div_op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// trial-subtract the divisor, emit one quotient bit.
module div_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;
    logic          fits;
    // The partial remainder stays below the divisor, so its top bit is always 0.
    logic          unused_rem_msb;

    assign unused_rem_msb = rem_in[XLEN];

    always_comb begin
        shifted = {rem_in[XLEN-1:0], quo_in[XLEN-1]};
        trial   = shifted - {1'b0, divisor};
        fits    = (shifted >= {1'b0, divisor});
        rem_out = fits ? trial : shifted;
        quo_out = {quo_in[XLEN-2:0], fits};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative XLEN-cycle restoring divider for DIV/DIVU/REM/REMU, with
// single-cycle handling of divide-by-zero and signed overflow.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_start,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            stall_req_ex
);

    localparam int unsigned CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN:0]   rem_nxt;
    logic [XLEN-1:0] quo_nxt;

    logic            start_ok;
    logic            is_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, overflow;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] quo_fin, rem_fin, res_fin;

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (rem_nxt),
        .quo_out (quo_nxt)
    );

    always_comb begin
        start_ok  = div_start & ~flush;
        is_signed = div_op_is_signed(div_op);
        a_neg     = is_signed & dividend[XLEN-1];
        b_neg     = is_signed & divisor[XLEN-1];
        a_abs     = a_neg ? -dividend : dividend;
        b_abs     = b_neg ? -divisor : divisor;
        div_zero  = (divisor == '0);
        overflow  = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
        if (div_zero) begin
            special_res = div_op_is_rem(div_op) ? dividend : '1;
        end else begin
            special_res = div_op_is_rem(div_op) ? '0 : dividend;
        end

        // Final sign fix-up is applied to the last step's outputs directly,
        // so the result is registered on the same edge that enters DONE.
        quo_fin = neg_quo_q ? -quo_nxt : quo_nxt;
        rem_fin = neg_rem_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];
        res_fin = div_op_is_rem(op_q) ? rem_fin : quo_fin;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            DIV_ST_IDLE: begin
                if (start_ok) begin
                    op_d      = div_op;
                    divisor_d = b_abs;
                    quo_d     = a_abs;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    if (div_zero || overflow) begin
                        result_d = special_res;
                        state_d  = DIV_ST_DONE;
                    end else begin
                        state_d  = DIV_ST_CALC;
                    end
                end
            end
            DIV_ST_CALC: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    result_d = res_fin;
                    state_d  = DIV_ST_DONE;
                end
            end
            DIV_ST_DONE: begin
                state_d = DIV_ST_IDLE;
            end
            default: begin
                state_d = DIV_ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d  = DIV_ST_IDLE;
            cnt_d    = '0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_ST_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    always_comb begin
        result       = result_q;
        result_valid = (state_q == DIV_ST_DONE);
        stall_req_ex = ~rst & (((state_q == DIV_ST_IDLE) & start_ok) | (state_q == DIV_ST_CALC));
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed table-driven bench for div_unit plus flush/reset/back-to-back sequences.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        div_start;
    logic [1:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic [31:0] result;
    logic        result_valid;
    logic        stall_req_ex;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int unsigned lat;
    } vec_t;

    localparam int unsigned NVEC = 20;
    vec_t vecs [NVEC];

    div_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .div_start    (div_start),
        .div_op       (div_op),
        .dividend     (dividend),
        .divisor      (divisor),
        .flush        (flush),
        .result       (result),
        .result_valid (result_valid),
        .stall_req_ex (stall_req_ex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int unsigned idx, input vec_t v);
        int unsigned lat;
        int unsigned stall_cnt;
        logic [31:0] held;
        string tag;
        tag = $sformatf("vec%0d", idx);
        div_start = 1'b1;
        div_op    = v.op;
        dividend  = v.a;
        divisor   = v.b;
        #1;
        check({tag, ".stall_start"}, 32'(stall_req_ex), 32'd1);
        stall_cnt = 1;
        tick();
        div_start = 1'b0;
        dividend  = 32'hDEAD_BEEF;
        divisor   = 32'h0000_0003;
        #1;
        lat = 1;
        while (!result_valid && lat < 40) begin
            if (stall_req_ex) stall_cnt++;
            tick();
            #1;
            lat++;
        end
        check({tag, ".latency"}, lat, v.lat);
        check({tag, ".result"}, result, v.exp);
        check({tag, ".stall_cycles"}, stall_cnt, v.lat);
        check({tag, ".stall_done"}, 32'(stall_req_ex), 32'd0);
        held = v.exp;
        tick();
        #1;
        check({tag, ".valid_after"}, 32'(result_valid), 32'd0);
        check({tag, ".hold"}, result, held);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        div_start = 1'b1;
        div_op    = 2'b01;
        dividend  = 32'd100;
        divisor   = 32'd7;
        flush     = 1'b0;

        vecs[0]  = '{op: 2'b01, a: 32'd100,        b: 32'd7,          exp: 32'd14,         lat: 33};
        vecs[1]  = '{op: 2'b11, a: 32'd100,        b: 32'd7,          exp: 32'd2,          lat: 33};
        vecs[2]  = '{op: 2'b10, a: 32'hFFFF_FFEC,  b: 32'd3,          exp: 32'hFFFF_FFFE,  lat: 33};
        vecs[3]  = '{op: 2'b00, a: 32'hFFFF_FFEC,  b: 32'd3,          exp: 32'hFFFF_FFFA,  lat: 33};
        vecs[4]  = '{op: 2'b00, a: 32'd20,         b: 32'hFFFF_FFFD,  exp: 32'hFFFF_FFFA,  lat: 33};
        vecs[5]  = '{op: 2'b10, a: 32'd20,         b: 32'hFFFF_FFFD,  exp: 32'd2,          lat: 33};
        vecs[6]  = '{op: 2'b00, a: 32'hFFFF_FFEC,  b: 32'hFFFF_FFFD,  exp: 32'd6,          lat: 33};
        vecs[7]  = '{op: 2'b10, a: 32'hFFFF_FFEC,  b: 32'hFFFF_FFFD,  exp: 32'hFFFF_FFFE,  lat: 33};
        vecs[8]  = '{op: 2'b01, a: 32'd5,          b: 32'd0,          exp: 32'hFFFF_FFFF,  lat: 1};
        vecs[9]  = '{op: 2'b11, a: 32'd5,          b: 32'd0,          exp: 32'd5,          lat: 1};
        vecs[10] = '{op: 2'b00, a: 32'hFFFF_FFEC,  b: 32'd0,          exp: 32'hFFFF_FFFF,  lat: 1};
        vecs[11] = '{op: 2'b10, a: 32'hFFFF_FFEC,  b: 32'd0,          exp: 32'hFFFF_FFEC,  lat: 1};
        vecs[12] = '{op: 2'b00, a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  exp: 32'h8000_0000,  lat: 1};
        vecs[13] = '{op: 2'b10, a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  exp: 32'd0,          lat: 1};
        vecs[14] = '{op: 2'b01, a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  exp: 32'd0,          lat: 33};
        vecs[15] = '{op: 2'b11, a: 32'h8000_0000,  b: 32'hFFFF_FFFF,  exp: 32'h8000_0000,  lat: 33};
        vecs[16] = '{op: 2'b01, a: 32'hFFFF_FFFF,  b: 32'd1,          exp: 32'hFFFF_FFFF,  lat: 33};
        vecs[17] = '{op: 2'b01, a: 32'd7,          b: 32'd100,        exp: 32'd0,          lat: 33};
        vecs[18] = '{op: 2'b11, a: 32'd7,          b: 32'd100,        exp: 32'd7,          lat: 33};
        vecs[19] = '{op: 2'b00, a: 32'h8000_0000,  b: 32'd2,          exp: 32'hC000_0000,  lat: 33};

        // Reset state, with div_start held high during reset.
        #1;
        check("rst.stall_in_reset", 32'(stall_req_ex), 32'd0);
        tick();
        tick();
        #1;
        check("rst.result", result, 32'd0);
        check("rst.valid", 32'(result_valid), 32'd0);
        check("rst.stall_in_reset2", 32'(stall_req_ex), 32'd0);
        rst       = 1'b0;
        div_start = 1'b0;
        #1;
        check("rst.stall_idle", 32'(stall_req_ex), 32'd0);

        for (int i = 0; i < int'(NVEC); i++) begin
            run_vec(i, vecs[i]);
        end

        // Flush mid-CALC: abandon divide, no result.
        begin
            int unsigned seen;
            div_start = 1'b1;
            div_op    = 2'b01;
            dividend  = 32'd100;
            divisor   = 32'd7;
            tick();
            div_start = 1'b0;
            for (int c = 1; c < 10; c++) tick();
            flush = 1'b1;
            #1;
            check("flush.stall_calc", 32'(stall_req_ex), 32'd1);
            tick();
            flush = 1'b0;
            #1;
            check("flush.stall_after", 32'(stall_req_ex), 32'd0);
            check("flush.valid_after", 32'(result_valid), 32'd0);
            check("flush.result_hold", result, vecs[NVEC-1].exp);
            seen = 0;
            for (int c = 0; c < 40; c++) begin
                if (result_valid) seen++;
                tick();
            end
            check("flush.no_valid", seen, 0);
        end

        // Flush in IDLE suppresses the start.
        begin
            int unsigned seen;
            div_start = 1'b1;
            flush     = 1'b1;
            div_op    = 2'b01;
            dividend  = 32'd9;
            divisor   = 32'd0;
            #1;
            check("idleflush.stall", 32'(stall_req_ex), 32'd0);
            tick();
            div_start = 1'b0;
            flush     = 1'b0;
            seen = 0;
            for (int c = 0; c < 40; c++) begin
                #1;
                if (result_valid || stall_req_ex) seen++;
                tick();
            end
            check("idleflush.no_activity", seen, 0);
        end

        // Reset mid-CALC clears all outputs.
        begin
            int unsigned seen;
            div_start = 1'b1;
            div_op    = 2'b01;
            dividend  = 32'd100;
            divisor   = 32'd7;
            tick();
            div_start = 1'b0;
            for (int c = 0; c < 5; c++) tick();
            rst = 1'b1;
            #1;
            check("midrst.stall_in_reset", 32'(stall_req_ex), 32'd0);
            tick();
            rst = 1'b0;
            #1;
            check("midrst.result", result, 32'd0);
            check("midrst.valid", 32'(result_valid), 32'd0);
            check("midrst.stall", 32'(stall_req_ex), 32'd0);
            seen = 0;
            for (int c = 0; c < 40; c++) begin
                if (result_valid) seen++;
                tick();
            end
            check("midrst.no_valid", seen, 0);
        end

        // Back-to-back: DIVU 9/2 then REMU 9/2; start held during DONE is ignored.
        begin
            int unsigned n;
            div_start = 1'b1;
            div_op    = 2'b01;
            dividend  = 32'd9;
            divisor   = 32'd2;
            tick();
            div_start = 1'b0;
            n = 1;
            while (n < 33) begin
                tick();
                n++;
            end
            #1;
            check("b2b.valid1", 32'(result_valid), 32'd1);
            check("b2b.result1", result, 32'd4);
            div_start = 1'b1;
            div_op    = 2'b11;
            #1;
            check("b2b.stall_done", 32'(stall_req_ex), 32'd0);
            tick();
            #1;
            check("b2b.valid_t34", 32'(result_valid), 32'd0);
            check("b2b.stall_t34", 32'(stall_req_ex), 32'd1);
            tick();
            div_start = 1'b0;
            n = 35;
            while (n < 67) begin
                #1;
                if (result_valid) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b2b.early_valid: got valid at cycle offset %0d expected 67", n);
                end
                tick();
                n++;
            end
            #1;
            check("b2b.valid2", 32'(result_valid), 32'd1);
            check("b2b.result2", result, 32'd1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have div_start  input  1  EX-stage instruction is a divide/remainder op.
REQ-005 SHALL have div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have dividend  input  XLEN  rs1 value.
REQ-007 SHALL have divisor  input  XLEN  rs2 value.
REQ-008 SHALL have flush  input  1  cancel the current divide (branch redirect/exception).
REQ-009 SHALL have result  output  XLEN  quotient or remainder per latched div_op.
REQ-010 SHALL have result_valid  output  1  result valid this cycle.
REQ-011 SHALL have stall_req_ex  output  1  EX stall request to the pipeline stall controller.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE with div_start=1 and flush=0 SHALL latch div_op, operands and sign info, then go to CALC; to DONE directly on a special case.
REQ-014 CALC SHALL perform one radix-2 restoring step per cycle for exactly XLEN cycles, counted by a counter, then go to DONE.
REQ-015 DONE SHALL last one cycle, assert result_valid=1, and return to IDLE unconditionally, ignoring div_start that cycle.
REQ-016 stall_req_ex SHALL be combinational: 1 when (IDLE and div_start and not flush) or CALC; 0 in DONE and otherwise.
REQ-017 Normal latency: div_start sampled in IDLE at cycle T gives result_valid at cycle T+XLEN+1.
REQ-018 Signed ops (DIV, REM) SHALL divide absolute values; quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-019 Divisor zero SHALL give quotient all-ones and remainder = dividend, reaching DONE at T+1.
REQ-020 Signed overflow (dividend = most-negative, divisor = -1) SHALL give quotient = dividend and remainder 0, reaching DONE at T+1.
REQ-021 flush=1 in any state SHALL force IDLE next cycle with result_valid=0.
REQ-022 flush=1 in IDLE SHALL suppress starting a divide and force stall_req_ex=0.
REQ-023 Outside DONE, result SHALL hold its last value and result_valid SHALL be 0.
REQ-024 Intermediate arithmetic SHALL use an XLEN+1-bit partial remainder; results truncate to XLEN.

Reset
REQ-025 rst=1 SHALL force state IDLE, iteration counter 0, result 0, result_valid 0, and clear all latched operands.
REQ-026 rst SHALL take priority over flush and div_start.
REQ-027 rst asserted mid-CALC SHALL abandon the divide with no result_valid pulse.
REQ-028 stall_req_ex SHALL be 0 during reset.

Structure
REQ-029 The div_op encodings and FSM state encodings SHALL reside in the shared CPU definitions package, alongside the existing pipeline op constants.
REQ-030 One combinational sub-module, div_step, SHALL implement a single restoring iteration (shift, trial subtract, quotient bit); div_unit instantiates it once.
REQ-031 The block SHALL contain no multi-cycle combinational paths; one div_step per clock.

Verification
REQ-032 DIVU 100/7 started at T -> stall_req_ex=1 for T..T+32, result_valid=1 and result=14 at T+33.
REQ-033 REM -20/3 -> result=0xFFFFFFFE (-2); DIV -20/3 -> result=0xFFFFFFFA (-6).
REQ-034 DIVU 5/0 -> result=0xFFFFFFFF at T+1; REMU 5/0 -> result=5 at T+1.
REQ-035 DIV 0x80000000/0xFFFFFFFF -> result=0x80000000 at T+1; REM of the same operands -> result=0.
REQ-036 flush pulsed at T+10 of a DIVU -> IDLE at T+11, stall_req_ex=0, no result_valid; then rst asserted mid-CALC -> all outputs 0 next cycle.
REQ-037 Back-to-back: DIVU 9/2 then REMU 9/2 presented consecutively -> result 4 at T+33, second start at T+34, result 1 at T+67.
